// File: rtl/bitorder_pkg.sv
// rtl/bitorder_pkg.sv - shared types and helpers for the bit-order serializer
// State encoding, gap counter width and the parity helper.
package bitorder_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAR, ST_GAP} ser_state_t;

  localparam int GAP_W     = 4;
  localparam int PAR_MAX_W = 64;

  // Callers zero-extend narrower words; zero bits do not change the parity.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/vec_reverse.sv
// rtl/vec_reverse.sv - combinational bit reversal of a DATA_W-bit vector
module vec_reverse #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  for (genvar i = 0; i < DATA_W; i++) begin : g_rev
    assign dout[i] = din[DATA_W-1-i];
  end

endmodule

// File: rtl/bitorder_serializer.sv
// rtl/bitorder_serializer.sv - parallel-to-serial sender with per-word LSB/MSB-first order
// Optional parity bit after the data bits when PARITY_EN is defined.
module bitorder_serializer
  import bitorder_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int IDLE_GAP = 1
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              msb_first,
  output logic              sout,
  output logic              sout_valid,
  output logic              frame_start,
  output logic              frame_end
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam ser_state_t ST_AFTER_FRAME = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;

  ser_state_t        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [GAP_W-1:0]  r_gap, w_gap_nxt;
  logic              r_sout, w_sout_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_fs, w_fs_nxt;
  logic              r_fe, w_fe_nxt;
`ifdef PARITY_EN
  logic              r_par, w_par_nxt;
`endif

  logic [DATA_W-1:0] w_rev;
  logic [DATA_W-1:0] w_load;
  logic              w_accept;

  vec_reverse #(.DATA_W(DATA_W)) u_rev (
    .din  (din),
    .dout (w_rev)
  );

  // Reversing MSB-first words lets the shifter always emit bit 0 first.
  assign w_load    = msb_first ? w_rev : din;
  assign din_ready = (r_state == ST_IDLE);
  assign w_accept  = din_valid && din_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = '0;
    w_sout_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_fs_nxt    = 1'b0;
    w_fe_nxt    = 1'b0;
`ifdef PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_shift_nxt = {1'b0, w_load[DATA_W-1:1]};
          w_cnt_nxt   = '0;
          w_sout_nxt  = w_load[0];
          w_valid_nxt = 1'b1;
          w_fs_nxt    = 1'b1;
`ifdef PARITY_EN
          w_par_nxt   = even_par(PAR_MAX_W'(din));
`endif
        end
      end
      ST_SHIFT: begin
        // r_cnt counts data bits already shown beyond the first one.
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef PARITY_EN
          w_state_nxt = ST_PAR;
          w_sout_nxt  = r_par;
          w_valid_nxt = 1'b1;
          w_fe_nxt    = 1'b1;
`else
          w_state_nxt = ST_AFTER_FRAME;
`endif
        end else begin
          w_sout_nxt  = r_shift[0];
          w_valid_nxt = 1'b1;
          w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
          w_cnt_nxt   = r_cnt + CNT_W'(1);
`ifndef PARITY_EN
          w_fe_nxt    = (r_cnt == CNT_W'(DATA_W - 2));
`endif
        end
      end
      ST_PAR: begin
        w_state_nxt = ST_AFTER_FRAME;
      end
      ST_GAP: begin
        if (r_gap == GAP_W'(IDLE_GAP - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_sout  <= 1'b0;
      r_valid <= 1'b0;
      r_fs    <= 1'b0;
      r_fe    <= 1'b0;
`ifdef PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_sout  <= w_sout_nxt;
      r_valid <= w_valid_nxt;
      r_fs    <= w_fs_nxt;
      r_fe    <= w_fe_nxt;
`ifdef PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign sout        = r_sout;
  assign sout_valid  = r_valid;
  assign frame_start = r_fs;
  assign frame_end   = r_fe;

endmodule
